// File: rtl/rom_arb_pkg.sv
// Shared types and helpers for the ROM read-port arbiter.
// FSM state encoding, latency counter width and the round-robin pick function.
package rom_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } arb_state_e;

    // Widest supported client vector; narrower vectors are zero-padded.
    localparam int unsigned MAX_REQ = 8;
    localparam int unsigned PTR_W   = 3;
    // Counts 0..RDLAT-1 for RDLAT up to 4.
    localparam int unsigned CNT_W   = 2;

    typedef struct packed {
        logic             valid;
        logic [PTR_W-1:0] idx;
        logic [MAX_REQ-1:0] onehot;
    } pick_t;

    // Masked-priority round robin: lowest request above ptr wins,
    // otherwise wrap to the lowest request overall.
    function automatic pick_t rr_pick(
        input logic [MAX_REQ-1:0] req,
        input logic [PTR_W-1:0]   ptr
    );
        logic [MAX_REQ-1:0] mask;
        logic [MAX_REQ-1:0] hi;
        logic [MAX_REQ-1:0] sel;
        pick_t              p;
        mask = 8'hFF << ({1'b0, ptr} + 4'd1);
        hi   = req & mask;
        sel  = (|hi) ? hi : req;
        p    = '0;
        for (int i = MAX_REQ - 1; i >= 0; i--) begin
            if (sel[i]) begin
                p.idx = i[PTR_W-1:0];
            end
        end
        p.valid  = |req;
        p.onehot = p.valid ? (8'd1 << p.idx) : 8'd0;
        return p;
    endfunction

endpackage

// File: rtl/rr_grant.sv
// Combinational round-robin picker, NREQ wide.
// Searches from ptr+1 upward and wraps at NREQ.
module rr_grant
    import rom_arb_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic             o_valid,
    output logic [NREQ-1:0]  o_gnt,
    output logic [PTR_W-1:0] o_idx
);

    logic [MAX_REQ-1:0] w_req;
    pick_t              w_pick;
    logic               w_unused;

    // Zero-pad the request vector so unused client slots never win.
    always_comb begin
        w_req             = '0;
        w_req[NREQ-1:0]   = i_req;
    end

    assign w_pick   = rr_pick(w_req, i_ptr);
    assign o_valid  = w_pick.valid;
    assign o_gnt    = w_pick.onehot[NREQ-1:0];
    assign o_idx    = w_pick.idx;
    assign w_unused = &{1'b0, w_pick.onehot};

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares one ROM read port among NREQ fetch clients, one access at a time.
// Optional ROMARB_PRIO0_EN: client 0 gets absolute priority over the rest.
module rom_port_arbiter
    import rom_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int AW    = 20,
    parameter int RDLAT = 1
) (
    input  logic             CL,
    input  logic             RSTn,
    input  logic [NREQ-1:0]  REQ,
    input  logic [NREQ*AW-1:0] AD,
    output logic [NREQ-1:0]  ACK,
    output logic [7:0]       DT,
    output logic [AW-1:0]    MAD,
    output logic             MRD,
    input  logic [7:0]       MDT,
    input  logic             DLEN,
    output logic             BUSY
);

    arb_state_e       r_state;
    arb_state_e       w_next;
    logic [PTR_W-1:0] r_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic [NREQ-1:0]  r_gnt;
    logic [AW-1:0]    r_mad;
    logic [7:0]       r_dt;

    logic [NREQ-1:0]  w_rr_req;
    logic             w_rr_valid;
    logic [NREQ-1:0]  w_rr_gnt;
    logic [PTR_W-1:0] w_rr_idx;

    logic             w_gnt_valid;
    logic [NREQ-1:0]  w_gnt;
    logic [PTR_W-1:0] w_gnt_idx;
    logic             w_ptr_upd;
    logic [AW-1:0]    w_gnt_ad;
    logic             w_take;
    logic             w_last;
    logic             w_mrd;

    // Requests that compete in the round-robin ring.
    always_comb begin
        w_rr_req = REQ;
`ifdef ROMARB_PRIO0_EN
        w_rr_req[0] = 1'b0;
`endif
    end

    rr_grant #(
        .NREQ    (NREQ)
    ) u_rr (
        .i_req   (w_rr_req),
        .i_ptr   (r_ptr),
        .o_valid (w_rr_valid),
        .o_gnt   (w_rr_gnt),
        .o_idx   (w_rr_idx)
    );

    // Final grant choice; client 0 bypasses the ring when prioritised.
    always_comb begin
        w_gnt_valid = w_rr_valid;
        w_gnt       = w_rr_gnt;
        w_gnt_idx   = w_rr_idx;
        w_ptr_upd   = w_rr_valid;
`ifdef ROMARB_PRIO0_EN
        if (REQ[0]) begin
            w_gnt_valid = 1'b1;
            w_gnt       = '0;
            w_gnt[0]    = 1'b1;
            w_gnt_idx   = '0;
            w_ptr_upd   = 1'b0;
        end
`endif
    end

    // Select the granted client's address.
    always_comb begin
        w_gnt_ad = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) begin
                w_gnt_ad = AD[i*AW +: AW];
            end
        end
    end

    assign w_take = (r_state == S_IDLE) && !DLEN && w_gnt_valid;
    assign w_last = (r_cnt == CNT_W'(RDLAT - 1));

    // State register.
    always_ff @(posedge CL) begin
        if (!RSTn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and strobe decode.
    always_comb begin
        w_next = r_state;
        w_mrd  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_take) begin
                    w_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_mrd  = 1'b1;
                w_next = S_WAIT;
            end
            S_WAIT: begin
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Latch grant, address and advance the ring pointer on a grant only.
    always_ff @(posedge CL) begin
        if (!RSTn) begin
            r_gnt <= '0;
            r_mad <= '0;
            r_ptr <= PTR_W'(NREQ - 1);
        end else if (w_take) begin
            r_gnt <= w_gnt;
            r_mad <= w_gnt_ad;
            if (w_ptr_upd) begin
                r_ptr <= w_gnt_idx;
            end
        end
    end

    // Read latency counter, restarted on every issue.
    always_ff @(posedge CL) begin
        if (!RSTn) begin
            r_cnt <= '0;
        end else if (r_state == S_ISSUE) begin
            r_cnt <= '0;
        end else if (r_state == S_WAIT) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Capture ROM data in the last wait cycle; held until the next capture.
    always_ff @(posedge CL) begin
        if (!RSTn) begin
            r_dt <= 8'h00;
        end else if ((r_state == S_WAIT) && w_last) begin
            r_dt <= MDT;
        end
    end

    // One-cycle acknowledge to the granted client.
    always_comb begin
        ACK = '0;
        if (r_state == S_DONE) begin
            ACK = r_gnt;
        end
    end

    assign DT   = r_dt;
    assign MAD  = r_mad;
    assign MRD  = w_mrd;
    assign BUSY = (r_state != S_IDLE);

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed bench for rom_port_arbiter with a registered ROM model.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_rom_port_arbiter;

    localparam int NREQ  = 4;
    localparam int AW    = 20;
    localparam int RDLAT = 1;

    logic              CL   = 1'b0;
    logic              RSTn = 1'b0;
    logic [NREQ-1:0]   REQ  = '0;
    logic [NREQ*AW-1:0] AD  = '0;
    logic [NREQ-1:0]   ACK;
    logic [7:0]        DT;
    logic [AW-1:0]     MAD;
    logic              MRD;
    logic [7:0]        MDT  = 8'h00;
    logic              DLEN = 1'b0;
    logic              BUSY;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [3:0]  ack_q[$];
    logic [7:0]  dt_q[$];
    int          ack_cyc_q[$];
    logic [19:0] mad_q[$];
    int          mrd_cyc_q[$];

    rom_port_arbiter #(
        .NREQ  (NREQ),
        .AW    (AW),
        .RDLAT (RDLAT)
    ) dut (
        .CL    (CL),
        .RSTn  (RSTn),
        .REQ   (REQ),
        .AD    (AD),
        .ACK   (ACK),
        .DT    (DT),
        .MAD   (MAD),
        .MRD   (MRD),
        .MDT   (MDT),
        .DLEN  (DLEN),
        .BUSY  (BUSY)
    );

    always #5 CL = ~CL;

    function automatic logic [7:0] rom_f(input logic [19:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ {4'h0, a[19:16]} ^ 8'hA5;
    endfunction

    // ROM array: one-cycle registered read.
    always @(posedge CL) begin
        if (MRD) MDT <= rom_f(MAD);
    end

    task automatic step(input logic [3:0] drop);
        @(negedge CL);
        cyc++;
        if (MRD) begin
            mad_q.push_back(MAD);
            mrd_cyc_q.push_back(cyc);
        end
        if (|ACK) begin
            ack_q.push_back(ACK);
            dt_q.push_back(DT);
            ack_cyc_q.push_back(cyc);
            REQ = REQ & ~(ACK & drop);
        end
    endtask

    task automatic clear_q();
        ack_q.delete();
        dt_q.delete();
        ack_cyc_q.delete();
        mad_q.delete();
        mrd_cyc_q.delete();
    endtask

    task automatic wait_acks(input int n, input int budget,
                             input logic [3:0] drop, input string name);
        int k = 0;
        while (ack_q.size() < n && k < budget) begin
            step(drop);
            k++;
        end
        checks++;
        if (ack_q.size() < n) begin
            errors++;
            $display("FAIL %s: acks seen %0d, required %0d",
                     name, ack_q.size(), n);
        end
    endtask

    task automatic do_reset();
        RSTn = 1'b0;
        REQ  = '0;
        DLEN = 1'b0;
        step(4'h0);
        step(4'h0);
        RSTn = 1'b1;
    endtask

    task automatic test_reset();
        RSTn = 1'b0;
        REQ  = '0;
        DLEN = 1'b0;
        repeat (3) step(4'h0);
        checks++;
        if (ACK !== 4'h0) begin
            errors++; $display("FAIL rst_ack: got %h want 0", ACK);
        end
        checks++;
        if (DT !== 8'h00) begin
            errors++; $display("FAIL rst_dt: got %h want 00", DT);
        end
        checks++;
        if (MAD !== 20'h0) begin
            errors++; $display("FAIL rst_mad: got %h want 0", MAD);
        end
        checks++;
        if (MRD !== 1'b0) begin
            errors++; $display("FAIL rst_mrd: got %b want 0", MRD);
        end
        checks++;
        if (BUSY !== 1'b0) begin
            errors++; $display("FAIL rst_busy: got %b want 0", BUSY);
        end
        RSTn = 1'b1;
        step(4'h0);
    endtask

    task automatic test_single();
        int c0;
        clear_q();
        AD[19:0] = 20'h34010;
        REQ = 4'b0001;
        c0 = cyc;
        wait_acks(1, 10, 4'b0001, "single_ack");
        checks++;
        if (ack_q[0] !== 4'b0001) begin
            errors++; $display("FAIL single_vec: got %b want 0001", ack_q[0]);
        end
        checks++;
        if (ack_cyc_q[0] != c0 + 3) begin
            errors++;
            $display("FAIL single_lat: got %0d want %0d", ack_cyc_q[0] - c0, 3);
        end
        checks++;
        if (dt_q[0] !== rom_f(20'h34010)) begin
            errors++;
            $display("FAIL single_dt: got %h want %h", dt_q[0], rom_f(20'h34010));
        end
        checks++;
        if (mrd_cyc_q[0] != c0 + 1 || mad_q[0] !== 20'h34010) begin
            errors++;
            $display("FAIL single_mrd: got cyc %0d mad %h want cyc 1 mad 34010",
                     mrd_cyc_q[0] - c0, mad_q[0]);
        end
        repeat (4) step(4'h0);
        checks++;
        if (mad_q.size() != 1 || MAD !== 20'h34010 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL single_hold: got mrds %0d mad %h busy %b want 1 34010 0",
                     mad_q.size(), MAD, BUSY);
        end
    endtask

    task automatic test_round_robin();
        int c0;
        int eidx[5] = '{0, 1, 2, 3, 0};
        logic [19:0] ea;
        do_reset();
        clear_q();
        AD = {20'h7F003, 20'h50A02, 20'h2C001, 20'h11000};
        REQ = 4'b1111;
        c0 = cyc;
        wait_acks(5, 40, 4'b0000, "rr_acks");
        REQ = '0;
        for (int i = 0; i < 5; i++) begin
            ea = AD[eidx[i]*AW +: AW];
            checks++;
            if (ack_q[i] !== (4'b0001 << eidx[i])) begin
                errors++;
                $display("FAIL rr_order[%0d]: got %b want client %0d",
                         i, ack_q[i], eidx[i]);
            end
            checks++;
            if (dt_q[i] !== rom_f(ea) || ack_cyc_q[i] != c0 + 3 + 4 * i) begin
                errors++;
                $display("FAIL rr_data[%0d]: got dt %h at %0d want %h at %0d",
                         i, dt_q[i], ack_cyc_q[i] - c0, rom_f(ea), 3 + 4 * i);
            end
        end
        repeat (2) step(4'h0);
    endtask

    task automatic test_dlen();
        int c0;
        clear_q();
        AD[1*AW +: AW] = 20'h0ABCD;
        AD[2*AW +: AW] = 20'h12345;
        DLEN = 1'b1;
        REQ  = 4'b0110;
        repeat (8) step(4'b0110);
        checks++;
        if (mad_q.size() != 0 || ack_q.size() != 0) begin
            errors++;
            $display("FAIL dlen_block: got mrds %0d acks %0d want 0 0",
                     mad_q.size(), ack_q.size());
        end
        DLEN = 1'b0;
        c0 = cyc;
        wait_acks(2, 20, 4'b0110, "dlen_release");
        checks++;
        if (ack_q[0] !== 4'b0010 || ack_q[1] !== 4'b0100) begin
            errors++;
            $display("FAIL dlen_order: got %b,%b want 0010,0100",
                     ack_q[0], ack_q[1]);
        end
        checks++;
        if (dt_q[0] !== rom_f(20'h0ABCD) || dt_q[1] !== rom_f(20'h12345)
            || ack_cyc_q[0] != c0 + 3) begin
            errors++;
            $display("FAIL dlen_data: got %h,%h at %0d want %h,%h at 3",
                     dt_q[0], dt_q[1], ack_cyc_q[0] - c0,
                     rom_f(20'h0ABCD), rom_f(20'h12345));
        end
        step(4'h0);
        clear_q();
        AD[3*AW +: AW] = 20'hFEDCB;
        REQ = 4'b1000;
        c0 = cyc;
        step(4'b1000);
        step(4'b1000);
        DLEN = 1'b1;
        wait_acks(1, 10, 4'b1000, "dlen_inflight");
        checks++;
        if (ack_q[0] !== 4'b1000 || ack_cyc_q[0] != c0 + 3
            || dt_q[0] !== rom_f(20'hFEDCB)) begin
            errors++;
            $display("FAIL dlen_inflight_ack: got %b at %0d dt %h want 1000 at 3 dt %h",
                     ack_q[0], ack_cyc_q[0] - c0, dt_q[0], rom_f(20'hFEDCB));
        end
        REQ = 4'b0001;
        repeat (6) step(4'b0001);
        checks++;
        if (mad_q.size() != 1 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL dlen_reblock: got mrds %0d busy %b want 1 0",
                     mad_q.size(), BUSY);
        end
        DLEN = 1'b0;
        wait_acks(2, 10, 4'b0001, "dlen_drain");
        checks++;
        if (ack_q[1] !== 4'b0001) begin
            errors++; $display("FAIL dlen_drain_vec: got %b want 0001", ack_q[1]);
        end
        step(4'h0);
    endtask

    task automatic test_drop_mid();
        int c0;
        clear_q();
        AD[2*AW +: AW] = 20'h0C0DE;
        REQ = 4'b0100;
        c0 = cyc;
        step(4'h0);
        REQ = 4'b0000;
        AD[2*AW +: AW] = 20'h99999;
        wait_acks(1, 10, 4'h0, "drop_ack");
        checks++;
        if (ack_q[0] !== 4'b0100 || ack_cyc_q[0] != c0 + 3) begin
            errors++;
            $display("FAIL drop_vec: got %b at %0d want 0100 at 3",
                     ack_q[0], ack_cyc_q[0] - c0);
        end
        checks++;
        if (dt_q[0] !== rom_f(20'h0C0DE) || MAD !== 20'h0C0DE) begin
            errors++;
            $display("FAIL drop_addr: got dt %h mad %h want %h 0C0DE",
                     dt_q[0], MAD, rom_f(20'h0C0DE));
        end
        step(4'h0);
    endtask

    task automatic test_reset_mid();
        int c0;
        clear_q();
        AD[1*AW +: AW] = 20'h4567A;
        REQ = 4'b0010;
        step(4'h0);
        step(4'h0);
        checks++;
        if (BUSY !== 1'b1) begin
            errors++; $display("FAIL rmid_busy: got %b want 1", BUSY);
        end
        RSTn = 1'b0;
        step(4'h0);
        checks++;
        if (ACK !== 4'h0 || DT !== 8'h00 || BUSY !== 1'b0 || ack_q.size() != 0) begin
            errors++;
            $display("FAIL rmid_abort: got ack %b dt %h busy %b acks %0d want 0 00 0 0",
                     ACK, DT, BUSY, ack_q.size());
        end
        RSTn = 1'b1;
        c0 = cyc;
        wait_acks(1, 10, 4'b0010, "rmid_post");
        checks++;
        if (ack_q[0] !== 4'b0010 || ack_cyc_q[0] != c0 + 3
            || dt_q[0] !== rom_f(20'h4567A)) begin
            errors++;
            $display("FAIL rmid_serve: got %b at %0d dt %h want 0010 at 3 dt %h",
                     ack_q[0], ack_cyc_q[0] - c0, dt_q[0], rom_f(20'h4567A));
        end
        step(4'h0);
    endtask

    task automatic test_prio();
        logic [3:0] exp_v[4];
`ifdef ROMARB_PRIO0_EN
        exp_v = '{4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
        exp_v = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
`endif
        do_reset();
        clear_q();
        AD = {20'h7F003, 20'h50A02, 20'h2C001, 20'h11000};
        REQ = 4'b1111;
        wait_acks(4, 30, 4'b1110, "prio_acks");
        REQ = '0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ack_q[i] !== exp_v[i]) begin
                errors++;
                $display("FAIL prio_order[%0d]: got %b want %b",
                         i, ack_q[i], exp_v[i]);
            end
        end
        repeat (2) step(4'h0);
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_dlen();
        test_drop_mid();
        test_reset_mid();
        test_prio();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
